// File: rtl/tiny_nn_result_serializer.sv
// Result buffer for the tiny NN core: queues accumulated fp_t results in a
// circular buffer and streams each entry out as bytes, LSB first, over valid/ready.

package tiny_nn_pkg;
  typedef logic [15:0] fp_t;
endpackage

module tiny_nn_result_serializer
  import tiny_nn_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  fp_t                        result_i,
  input  logic                       result_capture_i,
  input  logic                       flush_i,
  output logic [7:0]                 out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overflow_o
);

  localparam int unsigned FpW   = $bits(fp_t);
  localparam int unsigned Beats = FpW / 8;
  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;

  typedef logic [Beats-1:0][7:0] beats_t;

  fp_t             mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic            overflow_q, overflow_d;

  logic   empty, full, handshake, last_beat, pop, push;
  beats_t head_bytes;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(Depth));
  assign handshake = !empty && out_ready_i;
  assign last_beat = (beat_q == BeatW'(Beats - 1));
  assign pop       = handshake && last_beat && !flush_i;
  // A full buffer still accepts a capture when the head entry leaves this cycle.
  assign push      = result_capture_i && !flush_i && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    beat_d     = beat_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      beat_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (handshake) begin
        beat_d = last_beat ? '0 : beat_q + BeatW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (result_capture_i && full && !pop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage carries no reset; only the control state above does.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= result_i;
    end
  end

  assign head_bytes  = beats_t'(mem_q[rd_ptr_q]);
  assign out_data_o  = empty ? 8'h00 : head_bytes[beat_q];
  assign out_valid_o = !empty;
  assign count_o     = count_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign overflow_o  = overflow_q;

endmodule
